// File: rtl/cobra_pkg.sv
// Shared types, instruction field positions and the decoder for the cobra_core_mc core.
package cobra_pkg;

  // ALU operation codes (RISC-V-style funct encoding carried in ALUOP)
  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLTS = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_SRA  = 5'b01101,
    ALU_EQ   = 5'b11000,
    ALU_NE   = 5'b11001,
    ALU_LTS  = 5'b11100,
    ALU_GES  = 5'b11101,
    ALU_LTU  = 5'b11110,
    ALU_GEU  = 5'b11111
  } alu_op_e;

  // Write-source selector
  typedef enum logic [1:0] {
    WS_CONST = 2'd0,
    WS_ALU   = 2'd1,
    WS_SW    = 2'd2,
    WS_IN    = 2'd3
  } ws_e;

  // Core control states
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    WAIT_IN = 2'd2,
    HALT    = 2'd3
  } state_e;

  // Instruction field positions
  localparam int J_BIT     = 31;
  localparam int B_BIT     = 30;
  localparam int WS_HI     = 29;
  localparam int WS_LO     = 28;
  localparam int CONST_HI  = 27;
  localparam int CONST_LO  = 5;
  localparam int ALUOP_HI  = 27;
  localparam int ALUOP_LO  = 23;
  localparam int RA1_HI    = 22;
  localparam int RA1_LO    = 18;
  localparam int RA2_HI    = 17;
  localparam int RA2_LO    = 13;
  localparam int OFFS_HI   = 12;
  localparam int OFFS_LO   = 5;
  localparam int WA_HI     = 4;
  localparam int WA_LO     = 0;
  localparam int CONST_W   = CONST_HI - CONST_LO + 1;
  localparam int OFFS_W    = OFFS_HI - OFFS_LO + 1;

  // Decoded view of an instruction word; CONST overlaps ALUOP/RA1/RA2/OFFS
  typedef struct packed {
    logic                j;
    logic                b;
    ws_e                 ws;
    logic [CONST_W-1:0]  cnst;
    alu_op_e             alu_op;
    logic [4:0]          ra1;
    logic [4:0]          ra2;
    logic [OFFS_W-1:0]   offs;
    logic [4:0]          wa;
  } instr_t;

  function automatic instr_t decode_instr(input logic [31:0] ir);
    instr_t d;
    d.j      = ir[J_BIT];
    d.b      = ir[B_BIT];
    d.ws     = ws_e'(ir[WS_HI:WS_LO]);
    d.cnst   = ir[CONST_HI:CONST_LO];
    d.alu_op = alu_op_e'(ir[ALUOP_HI:ALUOP_LO]);
    d.ra1    = ir[RA1_HI:RA1_LO];
    d.ra2    = ir[RA2_HI:RA2_LO];
    d.offs   = ir[OFFS_HI:OFFS_LO];
    d.wa     = ir[WA_HI:WA_LO];
    return d;
  endfunction

endpackage

// File: rtl/cobra_alu.sv
// Combinational ALU: computational ops drive result_o, compare ops drive flag_o.
module cobra_alu
  import cobra_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e          alu_op_i,
  input  logic [XLEN-1:0]  a_i,
  input  logic [XLEN-1:0]  b_i,
  output logic [XLEN-1:0]  result_o,
  output logic             flag_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  // Operation select; compare ops leave result at zero
  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (alu_op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLTS: result_o = XLEN'($signed(a_i) < $signed(b_i));
      ALU_SLTU: result_o = XLEN'(a_i < b_i);
      ALU_EQ:   flag_o   = (a_i == b_i);
      ALU_NE:   flag_o   = (a_i != b_i);
      ALU_LTS:  flag_o   = ($signed(a_i) < $signed(b_i));
      ALU_GES:  flag_o   = ($signed(a_i) >= $signed(b_i));
      ALU_LTU:  flag_o   = (a_i < b_i);
      ALU_GEU:  flag_o   = (a_i >= b_i);
      default: begin
        result_o = '0;
        flag_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cobra_core_mc.sv
// Multi-cycle CYBERcobra core: handshaked fetch, blocking input instruction, halt, registered output.
module cobra_core_mc
  import cobra_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int SW_W = 16,
  parameter int IN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SW_W-1:0]  sw_i,
  output logic             imem_req_o,
  output logic [PC_W-1:0]  imem_addr_o,
  input  logic             imem_valid_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic             in_valid_i,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             in_ready_o,
  output logic [XLEN-1:0]  out_o,
  output logic             out_valid_o,
  output logic             halted_o
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;
  logic              in_ready_q, in_ready_d;
  logic              req_q, req_d;

  // Register file: x0 is never written and always read as zero
  logic [XLEN-1:0]   rf_q [32];
  logic              rf_we;
  logic [4:0]        rf_wa;
  logic [XLEN-1:0]   rf_wd;

  instr_t            dec;
  logic [XLEN-1:0]   rd1, rd2;
  logic [XLEN-1:0]   alu_res;
  logic              alu_flag;
  logic [XLEN-1:0]   const_x, sw_x, in_x;
  logic [PC_W-1:0]   offs_x;

  assign dec     = decode_instr(ir_q);
  assign rd1     = (dec.ra1 == 5'd0) ? '0 : rf_q[dec.ra1];
  assign rd2     = (dec.ra2 == 5'd0) ? '0 : rf_q[dec.ra2];
  assign const_x = {{(XLEN-CONST_W){dec.cnst[CONST_W-1]}}, dec.cnst};
  assign sw_x    = {{(XLEN-SW_W){sw_i[SW_W-1]}}, sw_i};
  assign in_x    = {{(XLEN-IN_W){1'b0}}, in_data_i};
  assign offs_x  = {{(PC_W-OFFS_W-2){dec.offs[OFFS_W-1]}}, dec.offs, 2'b00};

  cobra_alu #(.XLEN(XLEN)) u_alu (
    .alu_op_i (dec.alu_op),
    .a_i      (rd1),
    .b_i      (rd2),
    .result_o (alu_res),
    .flag_o   (alu_flag)
  );

  // Next-state logic of the FETCH/EXEC/WAIT_IN/HALT controller and its registered outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    halted_d    = halted_q;
    in_ready_d  = in_ready_q;
    req_d       = req_q;
    rf_we       = 1'b0;
    rf_wa       = dec.wa;
    rf_wd       = const_x;
    case (state_q)
      FETCH: begin
        // First cycle after reset has req low; it rises and stays up until the word arrives
        if (req_q) begin
          if (imem_valid_i) begin
            ir_d    = imem_rdata_i;
            req_d   = 1'b0;
            state_d = EXEC;
          end else begin
            req_d = 1'b1;
          end
        end else begin
          req_d = 1'b1;
        end
      end
      EXEC: begin
        out_d       = rd1;
        out_valid_d = 1'b1;
        if (dec.j) begin
          if (dec.offs == '0) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d    = pc_q + offs_x;
            req_d   = 1'b1;
            state_d = FETCH;
          end
        end else if (dec.b) begin
          pc_d    = pc_q + (alu_flag ? offs_x : PC_STEP);
          req_d   = 1'b1;
          state_d = FETCH;
        end else begin
          case (dec.ws)
            WS_CONST: begin
              rf_we = 1'b1;
              rf_wd = const_x;
            end
            WS_ALU: begin
              rf_we = 1'b1;
              rf_wd = alu_res;
            end
            WS_SW: begin
              rf_we = 1'b1;
              rf_wd = sw_x;
            end
            WS_IN: begin
              rf_we = 1'b0;
            end
            default: begin
              rf_we = 1'b0;
            end
          endcase
          if (dec.ws == WS_IN) begin
            in_ready_d = 1'b1;
            state_d    = WAIT_IN;
          end else begin
            pc_d    = pc_q + PC_STEP;
            req_d   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WAIT_IN: begin
        if (in_valid_i && in_ready_q) begin
          rf_we      = 1'b1;
          rf_wd      = in_x;
          pc_d       = pc_q + PC_STEP;
          in_ready_d = 1'b0;
          req_d      = 1'b1;
          state_d    = FETCH;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      HALT: begin
        halted_d = 1'b1;
        req_d    = 1'b0;
      end
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      in_ready_q  <= in_ready_d;
      req_q       <= req_d;
    end
  end

  // Register-file write port; reset blocks writes but does not clear contents
  always_ff @(posedge clk_i) begin
    if (rst_ni && rf_we && (rf_wa != 5'd0)) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign in_ready_o  = in_ready_q;
  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_cobra_core_mc.sv
// Directed bench: a 32/32 and a 64/16 core run in lockstep on the same instruction stream.
module tb_cobra_core_mc;
  import cobra_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        in_valid;
  logic [15:0] in_data;

  logic        req32, req64, rdy32, rdy64, ov32, ov64, h32, h64;
  logic [31:0] addr32, out32;
  logic [15:0] addr64;
  logic [63:0] out64;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] pc_m;

  always #5 clk = ~clk;

  cobra_core_mc #(.XLEN(32), .PC_W(32), .SW_W(16), .IN_W(16)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .sw_i(sw),
    .imem_req_o(req32), .imem_addr_o(addr32), .imem_valid_i(imem_valid), .imem_rdata_i(imem_rdata),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy32),
    .out_o(out32), .out_valid_o(ov32), .halted_o(h32)
  );

  cobra_core_mc #(.XLEN(64), .PC_W(16), .SW_W(16), .IN_W(16)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .sw_i(sw),
    .imem_req_o(req64), .imem_addr_o(addr64), .imem_valid_i(imem_valid), .imem_rdata_i(imem_rdata),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rdy64),
    .out_o(out64), .out_valid_o(ov64), .halted_o(h64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (pc_m=%h)", nm, act, exp, pc_m);
    end
  endtask

  function automatic logic [31:0] f_const(input logic [4:0] wa, input logic [22:0] c);
    return {1'b0, 1'b0, 2'b00, c, wa};
  endfunction
  function automatic logic [31:0] f_alu(input alu_op_e op, input logic [4:0] ra1, input logic [4:0] ra2,
                                        input logic [4:0] wa);
    return {1'b0, 1'b0, 2'b01, op, ra1, ra2, 8'h00, wa};
  endfunction
  // Branch/jump carry WS=ALU and WA=x4 so any wrongful write would be visible in x4
  function automatic logic [31:0] f_br(input alu_op_e op, input logic [4:0] ra1, input logic [4:0] ra2,
                                       input logic [7:0] offs);
    return {1'b0, 1'b1, 2'b01, op, ra1, ra2, offs, 5'd4};
  endfunction
  function automatic logic [31:0] f_jmp(input logic [7:0] offs, input logic [4:0] ra1);
    return {1'b1, 1'b1, 2'b01, 5'b00000, ra1, 5'd0, offs, 5'd4};
  endfunction
  function automatic logic [31:0] f_sw(input logic [4:0] wa);
    return {1'b0, 1'b0, 2'b10, 23'd0, wa};
  endfunction
  function automatic logic [31:0] f_in(input logic [4:0] wa);
    return {1'b0, 1'b0, 2'b11, 23'd0, wa};
  endfunction
  function automatic logic [31:0] f_probe(input logic [4:0] r);
    return f_const(5'd0, {5'd0, r, 13'd0});
  endfunction

  // Serve one fetch with 'lat' extra wait cycles, then check the EXEC result
  task automatic run_instr(input logic [31:0] instr, input int lat, input bit chk_o,
                           input logic [63:0] e64, input logic [31:0] e32);
    int seen = 0;
    bit got  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (i > 0) @(negedge clk);
      if (req32 && req64) begin
        if (seen == 0) begin
          chk("fetch_addr32", {32'd0, addr32}, {32'd0, pc_m});
          chk("fetch_addr64", {48'd0, addr64}, {48'd0, pc_m[15:0]});
        end
        if (seen == lat) begin
          imem_valid = 1'b1;
          imem_rdata = instr;
          got        = 1'b1;
        end else begin
          imem_valid = 1'b0;
        end
        seen++;
      end else begin
        imem_valid = 1'b0;
        if (seen > 0) chk("req_held", {62'd0, req32, req64}, 64'd3);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout: no request seen, pc_m=%h", pc_m);
    end else begin
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk("exec_req_low", {62'd0, req32, req64}, 64'd0);
      @(negedge clk);
      chk("out_valid", {62'd0, ov32, ov64}, 64'd3);
      if (chk_o) begin
        chk("out32", {32'd0, out32}, {32'd0, e32});
        chk("out64", out64, e64);
      end
    end
  endtask

  task automatic load(input logic [4:0] wa, input logic [22:0] c);
    run_instr(f_const(wa, c), 0, 1'b0, 64'd0, 32'd0);
    pc_m = pc_m + 32'd4;
  endtask

  task automatic probe(input logic [4:0] r, input logic [63:0] e64, input logic [31:0] e32);
    run_instr(f_probe(r), 0, 1'b1, e64, e32);
    pc_m = pc_m + 32'd4;
  endtask

  task automatic do_reset(input bit ghost);
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out32", {32'd0, out32}, 64'd0);
    chk("rst_out64", out64, 64'd0);
    chk("rst_flags", {58'd0, ov32, ov64, h32, h64, rdy32, rdy64}, 64'd0);
    chk("rst_req", {62'd0, req32, req64}, 64'd0);
    rst_n = 1'b1;
    pc_m  = 32'd0;
    if (ghost) begin
      // Valid while req is still low must be ignored (it carries a halt)
      imem_valid = 1'b1;
      imem_rdata = f_jmp(8'h00, 5'd0);
    end
    @(negedge clk);
  endtask

  typedef struct {
    alu_op_e     op;
    logic [22:0] a;
    logic [22:0] b;
    logic [63:0] e64;
    logic [31:0] e32;
  } alu_vec_t;

  typedef struct {
    alu_op_e op;
    bit      taken;
  } br_vec_t;

  alu_vec_t at[10];
  br_vec_t  bt[6];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] a64;

    at[0] = '{ALU_ADD,  23'd5,       23'd7,     64'd12,                 32'd12};
    at[1] = '{ALU_SUB,  23'd5,       23'd7,     64'hFFFF_FFFF_FFFF_FFFE, 32'hFFFF_FFFE};
    at[2] = '{ALU_XOR,  23'h0F0,     23'h0FF,   64'h00F,                32'h00F};
    at[3] = '{ALU_OR,   23'h0F0,     23'h00F,   64'h0FF,                32'h0FF};
    at[4] = '{ALU_AND,  23'h0F0,     23'h03C,   64'h030,                32'h030};
    at[5] = '{ALU_SLL,  23'd1,       23'd33,    64'h2_0000_0000,        32'h2};
    at[6] = '{ALU_SRL,  23'h7FFFF8,  23'd1,     64'h7FFF_FFFF_FFFF_FFFC, 32'h7FFF_FFFC};
    at[7] = '{ALU_SRA,  23'h7FFFF8,  23'd1,     64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC};
    at[8] = '{ALU_SLTS, 23'h7FFFFF,  23'd0,     64'd1,                  32'd1};
    at[9] = '{ALU_SLTU, 23'h7FFFFF,  23'd1,     64'd0,                  32'd0};

    bt[0] = '{ALU_EQ,  1'b0};
    bt[1] = '{ALU_NE,  1'b1};
    bt[2] = '{ALU_LTS, 1'b1};
    bt[3] = '{ALU_GES, 1'b0};
    bt[4] = '{ALU_LTU, 1'b0};
    bt[5] = '{ALU_GEU, 1'b1};

    rst_n      = 1'b0;
    sw         = 16'h0000;
    imem_valid = 1'b0;
    imem_rdata = 32'd0;
    in_valid   = 1'b0;
    in_data    = 16'h0000;
    pc_m       = 32'd0;

    // 1: reset, ghost valid ignored, 3-cycle fetch latency
    do_reset(1'b1);
    run_instr(f_const(5'd1, 23'd5), 3, 1'b0, 64'd0, 32'd0);
    pc_m = pc_m + 32'd4;
    chk("not_halted", {62'd0, h32, h64}, 64'd0);
    probe(5'd1, 64'd5, 32'd5);

    // 2: branches and jump never write, EQ taken / NE not taken
    load(5'd1, 23'd7);
    load(5'd2, 23'd7);
    load(5'd4, 23'd9);
    run_instr(f_br(ALU_EQ, 5'd1, 5'd2, 8'd3), 1, 1'b1, 64'd7, 32'd7);
    pc_m = pc_m + 32'd12;
    run_instr(f_br(ALU_NE, 5'd1, 5'd2, 8'd3), 0, 1'b1, 64'd7, 32'd7);
    pc_m = pc_m + 32'd4;
    run_instr(f_jmp(8'd2, 5'd1), 0, 1'b1, 64'd7, 32'd7);
    pc_m = pc_m + 32'd8;
    probe(5'd4, 64'd9, 32'd9);

    // Compare ops as branch conditions: x1=-1, x2=1
    load(5'd1, 23'h7FFFFF);
    load(5'd2, 23'd1);
    for (int i = 0; i < 6; i++) begin
      run_instr(f_br(bt[i].op, 5'd1, 5'd2, 8'd2), 0, 1'b0, 64'd0, 32'd0);
      pc_m = pc_m + (bt[i].taken ? 32'd8 : 32'd4);
    end

    // ALU result table
    for (int i = 0; i < 10; i++) begin
      a64 = {{41{at[i].a[22]}}, at[i].a};
      load(5'd1, at[i].a);
      load(5'd2, at[i].b);
      run_instr(f_alu(at[i].op, 5'd1, 5'd2, 5'd3), 0, 1'b1, a64, a64[31:0]);
      pc_m = pc_m + 32'd4;
      probe(5'd3, at[i].e64, at[i].e32);
    end

    // 5: switch write sign-extends; x0 ignores writes
    sw = 16'h8001;
    run_instr(f_sw(5'd5), 0, 1'b0, 64'd0, 32'd0);
    pc_m = pc_m + 32'd4;
    sw = 16'h0000;
    probe(5'd5, 64'hFFFF_FFFF_FFFF_8001, 32'hFFFF_8001);
    load(5'd0, 23'h123);
    sw = 16'h7777;
    run_instr(f_sw(5'd0), 0, 1'b0, 64'd0, 32'd0);
    pc_m = pc_m + 32'd4;
    probe(5'd0, 64'd0, 32'd0);

    // 4: blocking input, 5 idle cycles then transfer
    run_instr(f_in(5'd3), 0, 1'b0, 64'd0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("in_ready_wait", {62'd0, rdy32, rdy64}, 64'd3);
      in_valid = 1'b0;
      @(negedge clk);
    end
    chk("in_ready_xfer", {62'd0, rdy32, rdy64}, 64'd3);
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'h1234;
    chk("in_ready_drop", {62'd0, rdy32, rdy64}, 64'd0);
    chk("req_after_in", {62'd0, req32, req64}, 64'd3);
    pc_m = pc_m + 32'd4;
    probe(5'd3, 64'h0000_0000_0000_BEEF, 32'h0000_BEEF);

    // 6a: reset during WAIT_IN with a concurrent in_valid
    load(5'd6, 23'h11);
    run_instr(f_in(5'd6), 0, 1'b0, 64'd0, 32'd0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0077;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    pc_m     = 32'd0;
    chk("rst_wait_rdy", {62'd0, rdy32, rdy64}, 64'd0);
    chk("rst_wait_req", {62'd0, req32, req64}, 64'd0);
    @(negedge clk);
    probe(5'd6, 64'h11, 32'h11);

    // 6b: reset during FETCH with a concurrent imem_valid
    load(5'd7, 23'h22);
    rst_n      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = f_const(5'd7, 23'h55);
    @(negedge clk);
    rst_n      = 1'b1;
    imem_valid = 1'b0;
    pc_m       = 32'd0;
    @(negedge clk);
    probe(5'd7, 64'h22, 32'h22);

    // 3: backwards jump wraps PC, then jump with OFFS=0 halts
    do_reset(1'b0);
    run_instr(f_jmp(8'hFF, 5'd0), 0, 1'b1, 64'd0, 32'd0);
    pc_m = pc_m - 32'd4;
    run_instr(f_jmp(8'h00, 5'd7), 0, 1'b1, 64'h22, 32'h22);
    chk("halted", {62'd0, h32, h64}, 64'd3);
    chk("halt_req", {62'd0, req32, req64}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      imem_valid = 1'b1;
      @(negedge clk);
      chk("halt_hold", {60'd0, h32, h64, req32, req64}, 64'hC);
      chk("halt_no_ov", {62'd0, ov32, ov64}, 64'd0);
    end
    imem_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
